// File: rtl/sdrc_req_arb_if.sv
// Request-side bundle between the requester ports and the SDRAM request
// arbiter. It also carries the single forwarded request toward the request
// generator.
interface sdrc_req_arb_if #(
  parameter int NP     = 4,
  parameter int APP_AW = 26,
  parameter int APP_RW = 9,
  parameter int ID_W   = 4
);
  // requester side (flattened per-port payloads, port k at [k*W +: W])
  logic [NP-1:0]        p_req;
  logic [NP*ID_W-1:0]   p_req_id;
  logic [NP*APP_AW-1:0] p_addr;
  logic [NP*APP_RW-1:0] p_len;
  logic [NP-1:0]        p_wr_n;
  logic [NP-1:0]        p_wrap;
  logic [NP-1:0]        p_ack;
  // request generator side
  logic                 req;
  logic [ID_W-1:0]      req_id;
  logic [APP_AW-1:0]    req_addr;
  logic [APP_RW-1:0]    req_len;
  logic                 req_wr_n;
  logic                 req_wrap;
  logic                 req_ack;
  logic [1:0]           req_port;
  logic                 zlen_err;

  // environment: requesters plus request generator
  modport master (
    output p_req, p_req_id, p_addr, p_len, p_wr_n, p_wrap, req_ack,
    input  p_ack, req, req_id, req_addr, req_len, req_wr_n, req_wrap,
           req_port, zlen_err
  );

  // arbiter
  modport slave (
    input  p_req, p_req_id, p_addr, p_len, p_wr_n, p_wrap, req_ack,
    output p_ack, req, req_id, req_addr, req_len, req_wr_n, req_wrap,
           req_port, zlen_err
  );
endinterface

// File: rtl/sdrc_req_arb.sv
// Round-robin arbiter sharing one SDRAM controller request port among NP
// requesters. It has an optional priority port with a starvation guard.
// The winner's payload is latched and held until the request generator
// acks it.
module sdrc_req_arb #(
  parameter int NP          = 4,
  parameter int APP_AW      = 26,
  parameter int APP_RW      = 9,
  parameter int ID_W        = 4,
  parameter int MAX_PRI_RUN = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_pri_en,
  input  logic [1:0]        cfg_pri_port,
  sdrc_req_arb_if.slave     bus
);
  localparam int PW = 2;
  localparam int CW = $clog2(MAX_PRI_RUN + 1);

  typedef enum logic [1:0] {IDLE, REQ, ZACK} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q;
  logic [CW-1:0]     pri_cnt_q;
  logic              pri_hit_q;   // current grant counts toward the priority run
  logic [PW-1:0]     req_port_q;
  logic [ID_W-1:0]   req_id_q;
  logic [APP_AW-1:0] req_addr_q;
  logic [APP_RW-1:0] req_len_q;
  logic              req_wr_n_q;
  logic              req_wrap_q;

  logic              pri_valid, pri_req, others_pend, force_rr, use_pri, ack;
  logic [NP-1:0]     pri_mask, rr_cand;
  logic [PW-1:0]     rr_win, win, idx;
  logic              rr_hit;
  logic [APP_RW-1:0] win_len;

  // A priority port index outside the port range disables the priority path.
  assign pri_valid   = cfg_pri_en && ({1'b0, cfg_pri_port} < 3'(NP));
  assign pri_mask    = pri_valid ? (NP'(1) << cfg_pri_port) : '0;
  assign pri_req     = |(bus.p_req & pri_mask);
  assign others_pend = |(bus.p_req & ~pri_mask);
  // Once the priority port has run MAX_PRI_RUN grants while others wait,
  // the next grant must go to some other port.
  assign force_rr    = (pri_cnt_q == CW'(MAX_PRI_RUN)) && others_pend;
  assign use_pri     = pri_req && !force_rr;
  assign rr_cand     = force_rr ? (bus.p_req & ~pri_mask) : bus.p_req;

  // Round-robin scan starting at rr_ptr; first requesting candidate wins.
  always_comb begin
    rr_win = '0;
    rr_hit = 1'b0;
    idx    = '0;
    for (int i = 0; i < NP; i++) begin
      idx = PW'((int'(rr_ptr_q) + i) % NP);
      if (!rr_hit && rr_cand[idx]) begin
        rr_hit = 1'b1;
        rr_win = idx;
      end
    end
  end

  assign win     = use_pri ? cfg_pri_port : rr_win;
  assign win_len = bus.p_len[win*APP_RW +: APP_RW];

  // Next-state and ack decode; p_ack is only possible in REQ or ZACK.
  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    case (state_q)
      IDLE: if (|bus.p_req) state_d = (win_len == '0) ? ZACK : REQ;
      REQ:  if (bus.req_ack) begin
              ack     = 1'b1;
              state_d = IDLE;
            end
      ZACK: begin
              ack     = 1'b1;
              state_d = IDLE;
            end
      default: state_d = IDLE;
    endcase
  end

  // State, winner latch, round-robin pointer and priority-run counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      pri_cnt_q  <= '0;
      pri_hit_q  <= 1'b0;
      req_port_q <= '0;
      req_id_q   <= '0;
      req_addr_q <= '0;
      req_len_q  <= '0;
      req_wr_n_q <= 1'b0;
      req_wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |bus.p_req) begin
        req_port_q <= win;
        req_id_q   <= bus.p_req_id[win*ID_W +: ID_W];
        req_addr_q <= bus.p_addr[win*APP_AW +: APP_AW];
        req_len_q  <= win_len;
        req_wr_n_q <= bus.p_wr_n[win];
        req_wrap_q <= bus.p_wrap[win];
        pri_hit_q  <= use_pri && others_pend;
      end
      if (ack) begin
        rr_ptr_q  <= (req_port_q == PW'(NP - 1)) ? '0 : req_port_q + 1'b1;
        pri_cnt_q <= !pri_hit_q ? '0 :
                     (pri_cnt_q == CW'(MAX_PRI_RUN)) ? pri_cnt_q : pri_cnt_q + 1'b1;
      end
    end
  end

  assign bus.p_ack    = ack ? (NP'(1) << req_port_q) : '0;
  assign bus.req      = (state_q == REQ);
  assign bus.zlen_err = (state_q == ZACK);
  assign bus.req_id   = req_id_q;
  assign bus.req_addr = req_addr_q;
  assign bus.req_len  = req_len_q;
  assign bus.req_wr_n = req_wr_n_q;
  assign bus.req_wrap = req_wrap_q;
  assign bus.req_port = req_port_q;
endmodule

// File: tb/tb_sdrc_req_arb.sv
// Directed bench for sdrc_req_arb: reset, single grant, round-robin,
// priority with starvation guard, zero-length drop, payload hold, and reset
// in the middle of a request.
module tb_sdrc_req_arb;
  localparam int NP = 4, APP_AW = 26, APP_RW = 9, ID_W = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cfg_pri_en;
  logic [1:0] cfg_pri_port;
  int         checks = 0;
  int         errors = 0;

  sdrc_req_arb_if #(.NP(NP), .APP_AW(APP_AW), .APP_RW(APP_RW), .ID_W(ID_W)) bus ();

  sdrc_req_arb #(.NP(NP), .APP_AW(APP_AW), .APP_RW(APP_RW), .ID_W(ID_W),
                 .MAX_PRI_RUN(4)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_pri_en(cfg_pri_en),
    .cfg_pri_port(cfg_pri_port), .bus(bus)
  );

  always #5 clk = ~clk;

  // Inputs change just after the falling edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_port(input int k, input logic [APP_AW-1:0] a,
                          input logic [APP_RW-1:0] l, input logic wr_n);
    bus.p_addr[k*APP_AW +: APP_AW] = a;
    bus.p_len[k*APP_RW +: APP_RW]  = l;
    bus.p_wr_n[k]                  = wr_n;
    bus.p_req_id[k*ID_W +: ID_W]   = ID_W'(k + 4);
    bus.p_wrap[k]                  = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    reset_n      = 1'b0;
    cfg_pri_en   = 1'b0;
    cfg_pri_port = 2'd0;
    bus.p_req    = '0;
    bus.p_req_id = '0;
    bus.p_addr   = '0;
    bus.p_len    = '0;
    bus.p_wr_n   = '0;
    bus.p_wrap   = '0;
    bus.req_ack  = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.req); end
    checks++; if (bus.p_ack !== 4'b0000) begin errors++; $display("FAIL reset_p_ack got %b exp 0000", bus.p_ack); end
    checks++; if (bus.req_port !== 2'd0) begin errors++; $display("FAIL reset_req_port got %0d exp 0", bus.req_port); end
    checks++; if (bus.zlen_err !== 1'b0) begin errors++; $display("FAIL reset_zlen got %b exp 0", bus.zlen_err); end
    checks++; if (bus.req_addr !== 26'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.req_addr); end
  endtask

  task automatic test_single();
    do_reset();
    set_port(2, 26'h0001000, 9'd8, 1'b0);
    bus.p_req = 4'b0100;
    tick(); #1;
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL single_req got %b exp 1", bus.req); end
    checks++; if (bus.req_addr !== 26'h0001000) begin errors++; $display("FAIL single_addr got %h exp 0001000", bus.req_addr); end
    checks++; if (bus.req_len !== 9'd8) begin errors++; $display("FAIL single_len got %0d exp 8", bus.req_len); end
    checks++; if (bus.req_wr_n !== 1'b0) begin errors++; $display("FAIL single_wr_n got %b exp 0", bus.req_wr_n); end
    checks++; if (bus.req_port !== 2'd2) begin errors++; $display("FAIL single_port got %0d exp 2", bus.req_port); end
    checks++; if (bus.req_id !== 4'd6) begin errors++; $display("FAIL single_id got %0d exp 6", bus.req_id); end
    checks++; if (bus.p_ack !== 4'b0000) begin errors++; $display("FAIL single_early_ack got %b exp 0000", bus.p_ack); end
    tick(); tick(); tick();
    bus.req_ack = 1'b1; #1;
    checks++; if (bus.p_ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b exp 0100", bus.p_ack); end
    tick();
    bus.req_ack = 1'b0; bus.p_req = '0; #1;
    checks++; if (bus.req !== 1'b0 || bus.p_ack !== 4'b0000) begin errors++; $display("FAIL single_after req=%b ack=%b exp 0 0000", bus.req, bus.p_ack); end
  endtask

  // Continuous requests with req_ack held high: one grant every two cycles.
  task automatic run_grants(input string tag, input int n, input logic [1:0] exp_seq [10]);
    for (int g = 0; g < n; g++) begin
      tick(); #1;
      checks++;
      if (bus.req !== 1'b1 || bus.req_port !== exp_seq[g] || bus.p_ack !== (4'b0001 << exp_seq[g])) begin
        errors++;
        $display("FAIL %s_grant%0d req=%b port=%0d ack=%b exp req=1 port=%0d", tag, g, bus.req, bus.req_port, bus.p_ack, exp_seq[g]);
      end
      tick(); #1;
      if (g == n - 1) bus.p_req = '0;
      checks++;
      if (bus.req !== 1'b0 || bus.p_ack !== 4'b0000) begin
        errors++;
        $display("FAIL %s_gap%0d req=%b ack=%b exp 0 0000", tag, g, bus.req, bus.p_ack);
      end
    end
    bus.req_ack = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_seq [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    do_reset();
    for (int k = 0; k < NP; k++) set_port(k, 26'(32'h100 * (k + 1)), 9'd4, 1'b1);
    bus.p_req = 4'b1111;
    bus.req_ack = 1'b1;
    run_grants("rr", 5, exp_seq);
  endtask

  task automatic test_priority();
    logic [1:0] exp_seq [10] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1};
    do_reset();
    cfg_pri_en = 1'b1; cfg_pri_port = 2'd3;
    set_port(1, 26'h0000200, 9'd2, 1'b1);
    set_port(3, 26'h0000300, 9'd2, 1'b1);
    bus.p_req = 4'b1010;
    bus.req_ack = 1'b1;
    run_grants("pri", 10, exp_seq);
  endtask

  task automatic test_zero_len();
    do_reset();
    set_port(0, 26'h0000040, 9'd0, 1'b1);
    set_port(1, 26'h0000080, 9'd3, 1'b1);
    bus.p_req = 4'b0001;
    tick(); #1;
    checks++; if (bus.p_ack !== 4'b0001) begin errors++; $display("FAIL zlen_ack got %b exp 0001", bus.p_ack); end
    checks++; if (bus.zlen_err !== 1'b1) begin errors++; $display("FAIL zlen_err got %b exp 1", bus.zlen_err); end
    checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL zlen_req got %b exp 0", bus.req); end
    bus.p_req = '0;
    tick(); #1;
    checks++; if (bus.zlen_err !== 1'b0 || bus.p_ack !== 4'b0000) begin errors++; $display("FAIL zlen_pulse err=%b ack=%b exp 0 0000", bus.zlen_err, bus.p_ack); end
    // rr_ptr now 1: with ports 0 and 1 requesting, port 1 wins.
    set_port(0, 26'h0000040, 9'd5, 1'b1);
    bus.p_req = 4'b0011;
    tick(); #1;
    checks++; if (bus.req !== 1'b1 || bus.req_port !== 2'd1) begin errors++; $display("FAIL zlen_rr_adv req=%b port=%0d exp 1 1", bus.req, bus.req_port); end
    bus.req_ack = 1'b1;
    tick(); #1;
    bus.req_ack = 1'b0; bus.p_req = '0;
  endtask

  task automatic test_payload_hold();
    do_reset();
    set_port(1, 26'h0ABCDE0, 9'd16, 1'b1);
    bus.p_req = 4'b0010;
    tick();
    set_port(1, 26'h3FFFFFF, 9'd5, 1'b0);
    #1;
    checks++; if (bus.req_addr !== 26'h0ABCDE0 || bus.req_len !== 9'd16) begin errors++; $display("FAIL hold_1 addr=%h len=%0d exp 0abcde0 16", bus.req_addr, bus.req_len); end
    tick(); #1;
    checks++; if (bus.req_addr !== 26'h0ABCDE0 || bus.req_wr_n !== 1'b1) begin errors++; $display("FAIL hold_2 addr=%h wr_n=%b exp 0abcde0 1", bus.req_addr, bus.req_wr_n); end
    bus.req_ack = 1'b1; #1;
    checks++; if (bus.p_ack !== 4'b0010 || bus.req_len !== 9'd16) begin errors++; $display("FAIL hold_ack ack=%b len=%0d exp 0010 16", bus.p_ack, bus.req_len); end
    tick();
    bus.req_ack = 1'b0; bus.p_req = '0;
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    set_port(3, 26'h0000777, 9'd7, 1'b0);
    set_port(1, 26'h0000111, 9'd1, 1'b1);
    bus.p_req = 4'b1000;
    tick(); #1;
    checks++; if (bus.req !== 1'b1 || bus.req_port !== 2'd3) begin errors++; $display("FAIL midrst_pre req=%b port=%0d exp 1 3", bus.req, bus.req_port); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1; bus.p_req = '0; #1;
    checks++; if (bus.req !== 1'b0 || bus.p_ack !== 4'b0000 || bus.req_port !== 2'd0) begin errors++; $display("FAIL midrst_post req=%b ack=%b port=%0d exp 0 0000 0", bus.req, bus.p_ack, bus.req_port); end
    bus.p_req = 4'b0010;
    tick(); #1;
    checks++; if (bus.req !== 1'b1 || bus.req_port !== 2'd1 || bus.req_addr !== 26'h0000111) begin errors++; $display("FAIL midrst_regrant req=%b port=%0d addr=%h exp 1 1 0000111", bus.req, bus.req_port, bus.req_addr); end
    bus.req_ack = 1'b1; #1;
    checks++; if (bus.p_ack !== 4'b0010) begin errors++; $display("FAIL midrst_ack got %b exp 0010", bus.p_ack); end
    tick();
    bus.req_ack = 1'b0; bus.p_req = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_zero_len();
    test_payload_hold();
    test_reset_mid_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdrc_req_arb.md
Name: sdrc_req_arb

Overview:
- Shares the single SDRAM controller application request port among NP requesters (e.g. CPU I-fetch, D-port, DMA, display).
- Arbitrates round-robin, with an optional high-priority port and a starvation guard.
- Latches the winner's request and presents it to the request generator's req/req_ack handshake.
- Exports the owning port index so the transfer-data path can be steered.

Parameters:
- NP, 4: number of requester ports. Port index width PW = 2; NP must be 2..4.
- APP_AW, 26: application address width.
- APP_RW, 9: request length width.
- ID_W, 4: request ID width.
- MAX_PRI_RUN, 4: maximum consecutive priority-port grants while another port is pending.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- cfg_pri_en  in  1  enables priority port
- cfg_pri_port  in  2  index of priority port
- p_req  in  NP  per-port request; held until p_ack
- p_req_id  in  NP*ID_W  per-port ID; port k occupies [k*ID_W +: ID_W]
- p_addr  in  NP*APP_AW  per-port address
- p_len  in  NP*APP_RW  per-port length in words
- p_wr_n  in  NP  per-port 0=write, 1=read
- p_wrap  in  NP  per-port wrap mode
- p_ack  out  NP  one-hot acceptance pulse
- req  out  1  request to request generator
- req_id  out  ID_W
- req_addr  out  APP_AW
- req_len  out  APP_RW
- req_wr_n  out  1
- req_wrap  out  1
- req_ack  in  1  acceptance from request generator
- req_port  out  2  port owning the last forwarded request
- zlen_err  out  1  one-cycle pulse: zero-length request dropped

Behaviour:
- Reset (synchronous, reset_n=0 at clk edge):
  - state=IDLE, rr_ptr=0, pri_run_cnt=0.
  - req=0, req_id/addr/len/wr_n/wrap=0, req_port=0, zlen_err=0, p_ack=0.
  - Reset mid-REQ abandons the request without acking the requester.
- States: IDLE, REQ, ZACK.
- IDLE, no p_req: remain in IDLE.
- IDLE, any p_req bit set: choose winner W combinationally, then at the clock edge:
  - Register W's payload into the req_* outputs and set req_port=W.
  - If W's p_len==0: go to ZACK.
  - Otherwise: req<=1 and go to REQ.
- Winner selection:
  - Priority path: if cfg_pri_en, p_req[cfg_pri_port]=1, and not (pri_run_cnt==MAX_PRI_RUN with another port pending), W=cfg_pri_port.
  - Otherwise W is the first requesting port scanning rr_ptr, rr_ptr+1, ... modulo NP.
- REQ:
  - req=1; payload is stable and ignores p_* changes.
  - When req_ack=1: p_ack[req_port]=1 in the same cycle (combinational), req<=0, go to IDLE.
- ZACK (one cycle): p_ack[req_port]=1 and zlen_err=1, then go to IDLE. req is never asserted for a zero-length request.
- On every ack:
  - rr_ptr <= (W+1) mod NP.
  - If W==cfg_pri_port, cfg_pri_en=1, and another port was pending: pri_run_cnt saturating-increments. Otherwise pri_run_cnt clears to 0.
  - A forced round-robin grant after MAX_PRI_RUN clears pri_run_cnt.
- Grant spacing: minimum 2 cycles from one req rise to the next (IDLE cycle mandatory). p_ack is asserted for exactly one cycle per grant.
- p_ack is gated by state, so it is never asserted in IDLE.
- cfg_pri_port >= NP is treated as priority disabled.
- cfg_* changes take effect at the next IDLE selection only.
- Simultaneous requests: exactly one winner per selection; the others stay pending untouched.
- A requester deasserting p_req before p_ack violates protocol; the latched request is still issued and acked.

Test Plan:
- Single requester: port 2 requests addr 0x0001000, len 8, write; req_ack 3 cycles after req → req 1 cycle after p_req, req_addr=0x0001000, req_len=8, req_wr_n=0, req_port=2; p_ack=4'b0100 in the req_ack cycle.
- Round-robin: all four ports request continuously, req_ack immediate, pri disabled → grant order 0,1,2,3,0; p_ack one-hot each; 2-cycle spacing between req rises.
- Priority + starvation: cfg_pri_en=1, cfg_pri_port=3, ports 3 and 1 requesting continuously, MAX_PRI_RUN=4 → grants 3,3,3,3,1,3,3,3,3,1.
- Zero-length: port 0 len=0 → p_ack[0] and zlen_err pulse 1 cycle after selection; req stays 0; rr_ptr advances to 1.
- Payload hold: during REQ, change p_addr/p_len of the owning port → req_addr/req_len unchanged until ack.
- Reset mid-REQ: reset_n=0 for 1 cycle while req=1 → next cycle req=0, p_ack=0, req_port=0; then port 1 requests and is granted normally.
